// File: rtl/sodor_scratchpad_responder_if.sv
// Sodor memory request/response bundle between the core-side router and a
// scratchpad responder.
interface sodor_scratchpad_responder_if;
  logic        io_req_valid;
  logic [31:0] io_req_bits_addr;
  logic [31:0] io_req_bits_data;
  logic        io_req_bits_fcn;
  logic [2:0]  io_req_bits_typ;
  logic        io_resp_valid;
  logic [31:0] io_resp_bits_data;
  logic        io_resp_error;
  logic [31:0] io_readCount;
  logic [31:0] io_writeCount;

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_fcn, io_req_bits_typ,
    input  io_resp_valid, io_resp_bits_data, io_resp_error, io_readCount, io_writeCount
  );

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_fcn, io_req_bits_typ,
    output io_resp_valid, io_resp_bits_data, io_resp_error, io_readCount, io_writeCount
  );
endinterface

// File: rtl/sodor_scratchpad_responder.sv
// Scratchpad responder: byte/half/word accesses on a local word array with a
// registered one-cycle response, sign/zero extension and error flagging.
module sodor_scratchpad_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h80000000,
  parameter int unsigned ADDR_WORD_BITS = 16
) (
  input logic                          clock,
  input logic                          reset,
  sodor_scratchpad_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6
  } mem_typ_e;

  logic [31:0]               off;
  logic                      in_range;
  logic                      aligned;
  logic                      legal;
  logic                      err;
  logic                      do_wr;
  logic                      do_rd;
  logic [3:0]                be;
  logic [31:0]               wdata;
  logic [ADDR_WORD_BITS-1:0] idx;

  logic [31:0] mem [0:(1 << ADDR_WORD_BITS)-1];
  logic [31:0] rd_word;

  logic        resp_valid;
  logic        resp_error;
  logic        rd_q;
  logic [1:0]  lane_q;
  logic [2:0]  typ_q;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] resp_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    off      = bus.io_req_bits_addr - BASE_ADDR;
    in_range = ({1'b0, off} < (33'd4 << ADDR_WORD_BITS));
    idx      = off[ADDR_WORD_BITS+1:2];
    aligned  = 1'b0;
    legal    = 1'b0;
    be       = '0;
    wdata    = '0;
    case (bus.io_req_bits_typ)
      MT_B, MT_BU: begin
        aligned = 1'b1;
        be      = 4'b0001 << bus.io_req_bits_addr[1:0];
        wdata   = {4{bus.io_req_bits_data[7:0]}};
      end
      MT_H, MT_HU: begin
        aligned = ~bus.io_req_bits_addr[0];
        be      = bus.io_req_bits_addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{bus.io_req_bits_data[15:0]}};
      end
      MT_W: begin
        aligned = (bus.io_req_bits_addr[1:0] == 2'b00);
        be      = '1;
        wdata   = bus.io_req_bits_data;
      end
      default: ;
    endcase
    // Unsigned types only make sense for loads.
    case (bus.io_req_bits_typ)
      MT_B, MT_H, MT_W: legal = 1'b1;
      MT_BU, MT_HU:     legal = ~bus.io_req_bits_fcn;
      default:          legal = 1'b0;
    endcase
    err   = ~(in_range & aligned & legal);
    do_wr = bus.io_req_valid &  bus.io_req_bits_fcn & ~err;
    do_rd = bus.io_req_valid & ~bus.io_req_bits_fcn & ~err;
  end

  // Array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset && do_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rd_word <= mem[idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      rd_q       <= 1'b0;
      lane_q     <= '0;
      typ_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      resp_valid <= bus.io_req_valid;
      resp_error <= bus.io_req_valid & err;
      rd_q       <= do_rd;
      lane_q     <= bus.io_req_bits_addr[1:0];
      typ_q      <= bus.io_req_bits_typ;
      rd_cnt     <= rd_cnt + 32'(do_rd);
      wr_cnt     <= wr_cnt + 32'(do_wr);
    end
  end

  always_comb begin
    byte_sel  = rd_word[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    resp_data = '0;
    if (rd_q) begin
      case (typ_q)
        MT_B:    resp_data = {{24{byte_sel[7]}}, byte_sel};
        MT_BU:   resp_data = {24'h0, byte_sel};
        MT_H:    resp_data = {{16{half_sel[15]}}, half_sel};
        MT_HU:   resp_data = {16'h0, half_sel};
        MT_W:    resp_data = rd_word;
        default: resp_data = '0;
      endcase
    end
  end

  assign bus.io_resp_valid     = resp_valid;
  assign bus.io_resp_error     = resp_error;
  assign bus.io_resp_bits_data = resp_data;
  assign bus.io_readCount      = rd_cnt;
  assign bus.io_writeCount     = wr_cnt;

endmodule

// File: tb/tb_sodor_scratchpad_responder.sv
// Randomized + directed bench for sodor_scratchpad_responder against a
// byte-addressed reference memory model.
module tb_sodor_scratchpad_responder;
    localparam logic [31:0] BASE = 32'h80000000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sodor_scratchpad_responder_if bus();

    sodor_scratchpad_responder #(
        .BASE_ADDR(BASE),
        .ADDR_WORD_BITS(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0]  mm [int unsigned];
    int unsigned rc = 0;
    int unsigned wc = 0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_data = '0;
    bit          exp_has_lit = 1'b0;
    logic [31:0] exp_lit = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rd_bytes(input int unsigned off, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int unsigned k = 0; k < n; k++) r[8*k +: 8] = mm[off + k];
        return r;
    endfunction

    // Reference: memory is a flat byte array; sizes and extension from typ.
    task automatic model(input bit v, input bit fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data);
        int unsigned off, size;
        bit ok;
        logic [31:0] r;
        exp_valid = v;
        exp_err   = 1'b0;
        exp_data  = '0;
        if (!v) return;
        off = addr - BASE;
        case (typ)
            3'd1, 3'd5: size = 1;
            3'd2, 3'd6: size = 2;
            3'd3:       size = 4;
            default:    size = 0;
        endcase
        ok = (size != 0) && !(fcn && (typ == 3'd5 || typ == 3'd6));
        ok = ok && (off < 32'h40000) && (addr % size == 0);
        if (!ok) begin
            exp_err = 1'b1;
        end else if (fcn) begin
            for (int unsigned k = 0; k < size; k++) mm[off + k] = data[8*k +: 8];
            wc++;
        end else begin
            r = rd_bytes(off, size);
            case (typ)
                3'd1:    exp_data = {{24{r[7]}}, r[7:0]};
                3'd2:    exp_data = {{16{r[15]}}, r[15:0]};
                default: exp_data = r;
            endcase
            rc++;
        end
    endtask

    task automatic check_resp();
        check("resp_valid", {31'b0, bus.io_resp_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("resp_error", {31'b0, bus.io_resp_error}, {31'b0, exp_err});
            check("resp_data", bus.io_resp_bits_data, exp_data);
            if (exp_has_lit) check("resp_literal", bus.io_resp_bits_data, exp_lit);
        end
        check("readCount", bus.io_readCount, rc);
        check("writeCount", bus.io_writeCount, wc);
    endtask

    task automatic cycle(input bit v, input bit fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data,
                         input bit has_lit = 1'b0, input logic [31:0] lit = '0);
        @(negedge clock);
        check_resp();
        bus.io_req_valid     = v;
        bus.io_req_bits_fcn  = fcn;
        bus.io_req_bits_typ  = typ;
        bus.io_req_bits_addr = addr;
        bus.io_req_bits_data = data;
        model(v, fcn, typ, addr, data);
        exp_has_lit = has_lit;
        exp_lit     = lit;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        bus.io_req_valid     = 1'b0;
        bus.io_req_bits_fcn  = 1'b0;
        bus.io_req_bits_typ  = 3'd0;
        bus.io_req_bits_addr = '0;
        bus.io_req_bits_data = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", {31'b0, bus.io_resp_valid}, 32'd0);
        check("rst_error", {31'b0, bus.io_resp_error}, 32'd0);
        check("rst_data", bus.io_resp_bits_data, 32'd0);
        check("rst_rcnt", bus.io_readCount, 32'd0);
        check("rst_wcnt", bus.io_writeCount, 32'd0);
        reset = 1'b1;
        repeat (5) idle();

        // Request presented as reset re-asserts must vanish.
        @(negedge clock);
        check_resp();
        bus.io_req_valid     = 1'b1;
        bus.io_req_bits_fcn  = 1'b1;
        bus.io_req_bits_typ  = 3'd3;
        bus.io_req_bits_addr = BASE + 32'h100;
        bus.io_req_bits_data = 32'h55AA55AA;
        reset = 1'b0;
        exp_valid = 1'b0;
        @(negedge clock);
        check("rst_drop_valid", {31'b0, bus.io_resp_valid}, 32'd0);
        reset = 1'b1;
        bus.io_req_valid = 1'b0;
        rc = 0;
        wc = 0;
        repeat (3) idle();

        cycle(1, 1, 3'd3, BASE + 32'h10, 32'hDEADBEEF, 1, 32'h0);
        cycle(1, 0, 3'd3, BASE + 32'h10, 32'h0, 1, 32'hDEADBEEF);
        cycle(1, 0, 3'd1, BASE + 32'h13, 32'h0, 1, 32'hFFFFFFDE);
        cycle(1, 0, 3'd5, BASE + 32'h13, 32'h0, 1, 32'h000000DE);
        cycle(1, 0, 3'd2, BASE + 32'h10, 32'h0, 1, 32'hFFFFBEEF);
        cycle(1, 0, 3'd6, BASE + 32'h12, 32'h0, 1, 32'h0000DEAD);
        cycle(1, 1, 3'd1, BASE + 32'h11, 32'h12345677, 1, 32'h0);
        cycle(1, 0, 3'd3, BASE + 32'h10, 32'h0, 1, 32'hDEAD77EF);
        idle();

        cycle(1, 0, 3'd3, BASE + 32'h2, 32'h0, 1, 32'h0);
        cycle(1, 1, 3'd3, 32'h80040000, 32'hFFFFFFFF, 1, 32'h0);
        cycle(1, 1, 3'd2, 32'h7FFFFFFE, 32'hFFFFFFFF, 1, 32'h0);
        cycle(1, 0, 3'd7, BASE + 32'h10, 32'h0, 1, 32'h0);
        cycle(1, 1, 3'd5, BASE + 32'h10, 32'hFFFFFFFF, 1, 32'h0);
        cycle(1, 0, 3'd3, BASE + 32'h10, 32'h0, 1, 32'hDEAD77EF);
        idle();

        for (int i = 0; i < 8; i++) cycle(1, 1, 3'd3, BASE + 32'(4 * i), 32'(i));
        for (int i = 0; i < 8; i++) cycle(1, 0, 3'd3, BASE + 32'(4 * i), 32'h0, 1, 32'(i));
        idle();

        cycle(1, 1, 3'd3, BASE + 32'h3FFF8, 32'hA5C3_1E77);
        cycle(1, 1, 3'd3, BASE + 32'h3FFFC, 32'h8001_7F80);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + $urandom_range(0, 31);
                3:       a = BASE + 32'h3FFF8 + $urandom_range(0, 7);
                4:       a = BASE + 32'h40000 + $urandom_range(0, 7);
                default: a = BASE - 32'd8 + $urandom_range(0, 7);
            endcase
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), a, $urandom);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sodor_scratchpad_responder.md
Name: sodor_scratchpad_responder

Overview:
- Responder end of the Sodor memory request/response interface. Sits behind the core-side request router on its scratchpad port.
- Accepts one request per cycle: valid, addr, data, fcn, typ.
- Performs byte/half/word reads and writes on a local synchronous word array.
- Returns a registered response exactly one cycle later, with sign/zero extension and error flagging.

Parameters:
BASE_ADDR, 32'h80000000, first byte address served
ADDR_WORD_BITS, 16, log2 of array depth in 32-bit words (default 65536 words = 0x40000 bytes)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
io_req_valid  in  1  request present this cycle
io_req_bits_addr  in  32  byte address
io_req_bits_data  in  32  store data, unshifted (value in low bits)
io_req_bits_fcn  in  1  0=read, 1=write
io_req_bits_typ  in  3  1=B, 2=H, 3=W, 5=BU, 6=HU; others illegal
io_resp_valid  out  1  response for the request of the previous cycle
io_resp_bits_data  out  32  read data, extended; 0 for writes and errors
io_resp_error  out  1  response is an error (range, alignment or illegal typ)
io_readCount  out  32  completed successful reads, wraps
io_writeCount  out  32  completed successful writes, wraps

Behaviour:
- Reset (reset low, asynchronous): io_resp_valid=0, io_resp_bits_data=0, io_resp_error=0, both counters=0.
  - Array contents are not reset.
  - A request captured in the cycle reset asserts is dropped; no response appears after reset release.
- Latency: request sampled at edge N -> io_resp_valid=1 for exactly one cycle after edge N.
  - No backpressure; back-to-back requests give back-to-back responses.
  - io_resp_valid=0 in every cycle after an edge at which io_req_valid=0.
- Range check: off = addr - BASE_ADDR (32-bit wrapping). In range iff off < 4<<ADDR_WORD_BITS. Word index = off[ADDR_WORD_BITS+1:2]; lane = addr[1:0].
- Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0; B/BU are always aligned.
- Error conditions: out of range, misaligned, or typ not in {1,2,3,5,6} (including writes with BU/HU).
  - Any error -> response has error=1, data=0, no array write, no counter increment.
- Write:
  - Byte enables: B -> 1 lane at addr[1:0]; H -> 2 lanes at addr[1]; W -> all 4.
  - Store data is replicated into lanes: B -> data[7:0] in each byte; H -> data[15:0] in each half.
  - Only enabled bytes are updated, at the sampling edge.
  - Response data=0, error=0; io_writeCount += 1.
- Read:
  - Array read is synchronous. The word is registered with the lane and typ, then extracted in the response cycle.
  - B: sign-extend byte[lane]. BU: zero-extend. H: sign-extend half[addr[1]]. HU: zero-extend. W: full word.
  - io_readCount += 1 in the response cycle.
- Ordering: a write at edge N followed by a read of the same word at edge N+1 returns the written data. There are no same-cycle read/write conflicts (one request per cycle).
- Counters: 32-bit, wrap 0xFFFFFFFF -> 0. Each increments at most once per cycle.
- Response fields are registered outputs; no combinational path from req to resp.

Test Plan:
- Reset release, then idle: io_resp_valid=0 and counters=0 for 5 cycles; after writing then re-asserting reset mid-request, io_resp_valid stays 0.
- Write W addr 0x80000010 data 0xDEADBEEF, next cycle read W same addr -> write resp {valid=1, data=0, error=0}; read resp data 0xDEADBEEF one cycle after the read request; writeCount=1, readCount=1.
- Byte/half extension, with word 0x80000010 = 0xDEADBEEF:
  - B at 0x80000013 -> 0xFFFFFFDE; BU -> 0x000000DE.
  - H at 0x80000010 -> 0xFFFFBEEF; HU at 0x80000012 -> 0x0000DEAD.
- Partial write: B write addr 0x80000011 data 0x12345677 to word 0xDEADBEEF, then W read -> 0xDEAD77EF.
- Errors, each -> error=1, data=0, counters unchanged, array unchanged:
  - W read at 0x80000002 (misaligned).
  - W write at 0x80040000 (out of range).
  - H write at 0x7FFFFFFE (out of range).
  - typ=7 read at 0x80000010 (illegal typ).
- Back-to-back: 8 consecutive W writes to 0x80000000..0x8000001C with data i, then 8 consecutive reads -> 8 consecutive resp_valid cycles returning 0..7 in order; writeCount=8, readCount=8.
